// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID slave and its boot-time checker.
// Holds the FSM encoding, word addresses and default expected values.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ID  = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_RD_TS  = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_FINISH = 3'd5
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1363017989;

  function automatic logic sysid_match(
    input logic [31:0] id_word,
    input logic [31:0] ts_word,
    input logic [31:0] exp_id,
    input logic [31:0] exp_ts
  );
    return (id_word == exp_id) && (ts_word == exp_ts);
  endfunction

endpackage

// File: rtl/sysid_read_engine.sv
// One Avalon-MM read: strobe and acceptance, fixed read latency wait,
// and a consecutive-waitrequest timeout. The caller owns the phase sequencing.
module sysid_read_engine #(
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rd_phase,
  input  logic        lat_phase,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        rd_strobe,
  output logic        accept,
  output logic        data_valid,
  output logic        timed_out,
  output logic [31:0] data
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LAT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  logic [15:0] wait_cnt;
  logic [1:0]  lat_cnt;

  assign rd_strobe  = rd_phase;
  assign accept     = rd_phase && !waitrequest;
  // Abort on the edge that would bring the stall count up to TIMEOUT.
  assign timed_out  = rd_phase && waitrequest && (wait_cnt == WAIT_LAST);
  assign data_valid = (READ_LATENCY == 0) ? accept : (lat_phase && (lat_cnt == LAT_LAST));
  assign data       = readdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      if (!rd_phase || accept || timed_out) begin
        wait_cnt <= '0;
      end else if (waitrequest) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (!lat_phase || data_valid) begin
        lat_cnt <= '0;
      end else begin
        lat_cnt <= lat_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads system ID (word 0) and build timestamp (word 1) from the sysid slave
// and flags whether the running FPGA image matches the expected build.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start or the post-reset auto check
// RD_ID     | read of word 0 on the bus
// LAT_ID    | waiting READ_LATENCY cycles for word 0 data
// RD_TS     | read of word 1 on the bus
// LAT_TS    | waiting READ_LATENCY cycles for word 1 data
// FINISH    | one-cycle done pulse, pass evaluated
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT            = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_t state, state_nxt;

  logic        auto_pend;
  logic        pass_q;
  logic        trigger;
  logic        rd_phase;
  logic        lat_phase;
  logic        accept;
  logic        data_valid;
  logic        timed_out;
  logic        finish_match;
  logic [31:0] rd_data;

  sysid_read_engine #(
    .READ_LATENCY (READ_LATENCY),
    .TIMEOUT      (TIMEOUT)
  ) u_read_engine (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_phase    (rd_phase),
    .lat_phase   (lat_phase),
    .waitrequest (av_waitrequest),
    .readdata    (av_readdata),
    .rd_strobe   (av_read),
    .accept      (accept),
    .data_valid  (data_valid),
    .timed_out   (timed_out),
    .data        (rd_data)
  );

  assign trigger      = start || auto_pend;
  assign finish_match = sysid_match(id_value, ts_value, EXPECTED_ID, EXPECTED_TIMESTAMP) && !timeout;
  // Live compare only during FINISH; the registered copy holds afterwards.
  assign pass         = (state == ST_FINISH) ? finish_match : pass_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_phase   = 1'b0;
    lat_phase  = 1'b0;
    av_address = SYSID_ADDR_ID;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (trigger) state_nxt = ST_RD_ID;
      end
      ST_RD_ID: begin
        rd_phase = 1'b1;
        if (timed_out)   state_nxt = ST_FINISH;
        else if (accept) state_nxt = (READ_LATENCY == 0) ? ST_RD_TS : ST_LAT_ID;
      end
      ST_LAT_ID: begin
        lat_phase = 1'b1;
        if (data_valid) state_nxt = ST_RD_TS;
      end
      ST_RD_TS: begin
        rd_phase   = 1'b1;
        av_address = SYSID_ADDR_TS;
        if (timed_out)   state_nxt = ST_FINISH;
        else if (accept) state_nxt = (READ_LATENCY == 0) ? ST_FINISH : ST_LAT_TS;
      end
      ST_LAT_TS: begin
        lat_phase = 1'b1;
        if (data_valid) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pend <= AUTO_START;
      pass_q    <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      if (state == ST_IDLE && trigger) begin
        auto_pend <= 1'b0;
        pass_q    <= 1'b0;
        timeout   <= 1'b0;
      end
      if (timed_out) timeout <= 1'b1;
      if (state == ST_FINISH) pass_q <= finish_match;
      if (data_valid && (state == ST_RD_ID || state == ST_LAT_ID)) id_value <= rd_data;
      if (data_valid && (state == ST_RD_TS || state == ST_LAT_TS)) ts_value <= rd_data;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a combinational slave (dut_a) and a latency-2,
// stall-capable slave with TIMEOUT=8 (dut_b), checked against outcome rules.
module tb_sysid_checker;

  localparam logic [31:0] EXP_TS   = 32'd1363017989;
  localparam logic [31:0] B_EXP_ID = 32'h1234_5678;
  localparam int          B_LAT    = 2;
  localparam int          B_TO     = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, start_a, av_address_a, av_read_a, av_waitrequest_a;
  logic        busy_a, done_a, pass_a, timeout_a;
  logic [31:0] av_readdata_a, id_value_a, ts_value_a;
  logic        rst_b, start_b, av_address_b, av_read_b, av_waitrequest_b;
  logic        busy_b, done_b, pass_b, timeout_b;
  logic [31:0] av_readdata_b, id_value_b, ts_value_b;

  logic [31:0] id_word_a, ts_word_a, id_word_b, ts_word_b;
  int          stall_req_b [2];
  int          stall_seen_b [2];
  logic [1:0]  pipe0_b, pipe1_b;

  logic [31:0] mdl_id_b, mdl_ts_b;
  int total = 0;
  int bad   = 0;

  sysid_checker dut_a (
    .clock(clock), .reset_n(rst_a), .start(start_a),
    .av_address(av_address_a), .av_read(av_read_a), .av_waitrequest(av_waitrequest_a),
    .av_readdata(av_readdata_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .timeout(timeout_a), .id_value(id_value_a), .ts_value(ts_value_a)
  );

  sysid_checker #(
    .EXPECTED_ID(B_EXP_ID), .READ_LATENCY(B_LAT), .TIMEOUT(B_TO), .AUTO_START(1'b1)
  ) dut_b (
    .clock(clock), .reset_n(rst_b), .start(start_b),
    .av_address(av_address_b), .av_read(av_read_b), .av_waitrequest(av_waitrequest_b),
    .av_readdata(av_readdata_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .timeout(timeout_b), .id_value(id_value_b), .ts_value(ts_value_b)
  );

  // Slave A: zero-latency, never stalls.
  assign av_waitrequest_a = 1'b0;
  assign av_readdata_a    = av_address_a ? ts_word_a : id_word_a;

  // Slave B: per-address stall budget, data valid only exactly B_LAT edges after acceptance.
  assign av_waitrequest_b = av_read_b && (stall_seen_b[av_address_b] < stall_req_b[av_address_b]);
  assign av_readdata_b    = pipe1_b[1] ? (pipe1_b[0] ? ts_word_b : id_word_b) : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    if (!rst_b || done_b) begin
      stall_seen_b[0] <= 0;
      stall_seen_b[1] <= 0;
    end else if (av_read_b && av_waitrequest_b) begin
      stall_seen_b[av_address_b] <= stall_seen_b[av_address_b] + 1;
    end
    pipe0_b <= (rst_b && av_read_b && !av_waitrequest_b) ? {1'b1, av_address_b} : 2'b00;
    pipe1_b <= rst_b ? pipe0_b : 2'b00;
  end

  // Observes one check whose trigger is the next posedge; returns cycle index of done
  // (start cycle = 0), bus activity counts and pass/timeout seen with done.
  task automatic watch(input bit b, input int restart_at, output int lat, output int rd_cyc,
                       output int acc, output int dones, output logic pass_d, output logic to_d);
    logic rd, wt, ad, dn, prev_stall, prev_addr;
    int tail;
    lat = -1; rd_cyc = 0; acc = 0; dones = 0; pass_d = 1'b0; to_d = 1'b0;
    prev_stall = 1'b0; prev_addr = 1'b0; tail = -1;
    @(posedge clock);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clock);
      if (n == restart_at) begin
        if (b) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      rd = b ? av_read_b : av_read_a;
      wt = b ? av_waitrequest_b : av_waitrequest_a;
      ad = b ? av_address_b : av_address_a;
      dn = b ? done_b : done_a;
      if (rd) begin
        rd_cyc++;
        if (prev_stall) begin
          total++;
          if (ad !== prev_addr) begin
            bad++; $display("FAIL addr_stable cycle=%0d got=%b want=%b", n, ad, prev_addr);
          end
        end
        if (!wt) begin
          total++;
          if (ad !== (acc != 0)) begin
            bad++; $display("FAIL read_addr read=%0d got=%b want=%b", acc, ad, (acc != 0));
          end
          acc++;
        end
      end
      prev_stall = rd && wt;
      prev_addr  = ad;
      if (dn) begin
        dones++;
        if (lat < 0) begin
          lat = n; tail = n + 8;
          pass_d = b ? pass_b : pass_a;
          to_d   = b ? timeout_b : timeout_a;
        end
      end
      if (n == tail) break;
    end
    total++;
    if (lat < 0) begin
      bad++; $display("FAIL done_wait got=no_done want=done_within_400");
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    id_word_a = 32'd0; ts_word_a = EXP_TS; id_word_b = B_EXP_ID; ts_word_b = EXP_TS;
    stall_req_b[0] = 0; stall_req_b[1] = 0;
    mdl_id_b = 32'd0; mdl_ts_b = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({av_read_a, av_address_a, busy_a, done_a, pass_a, timeout_a, id_value_a, ts_value_a} !== 70'd0) begin
      bad++; $display("FAIL reset_a got=%b%b%b%b%b%b %h %h want=all_zero", av_read_a, av_address_a,
                      busy_a, done_a, pass_a, timeout_a, id_value_a, ts_value_a);
    end
    total++;
    if ({av_read_b, av_address_b, busy_b, done_b, pass_b, timeout_b, id_value_b, ts_value_b} !== 70'd0) begin
      bad++; $display("FAIL reset_b got=%b%b%b%b%b%b %h %h want=all_zero", av_read_b, av_address_b,
                      busy_b, done_b, pass_b, timeout_b, id_value_b, ts_value_b);
    end
  endtask

  task automatic test_auto_start();
    int lat, rdc, acc, dn; logic pd, td;
    rst_a = 1'b1; rst_b = 1'b1;
    watch(1'b0, 0, lat, rdc, acc, dn, pd, td);
    total++;
    if (lat !== 3 || rdc !== 2 || acc !== 2 || dn !== 1) begin
      bad++; $display("FAIL auto_seq got lat=%0d rd=%0d acc=%0d done=%0d want 3 2 2 1", lat, rdc, acc, dn);
    end
    total++;
    if (pd !== 1'b1 || td !== 1'b0 || id_value_a !== 32'd0 || ts_value_a !== EXP_TS) begin
      bad++; $display("FAIL auto_result got pass=%b to=%b id=%h ts=%h want 1 0 0 %h", pd, td, id_value_a, ts_value_a, EXP_TS);
    end
    repeat (4) @(negedge clock);
    mdl_id_b = B_EXP_ID; mdl_ts_b = EXP_TS;
    total++;
    if (busy_b !== 1'b0 || pass_b !== 1'b1 || id_value_b !== B_EXP_ID || ts_value_b !== EXP_TS) begin
      bad++; $display("FAIL auto_b got busy=%b pass=%b id=%h ts=%h want 0 1 %h %h", busy_b, pass_b, id_value_b, ts_value_b, B_EXP_ID, EXP_TS);
    end
  endtask

  task automatic test_id_mismatch();
    int lat, rdc, acc, dn; logic pd, td;
    id_word_a = 32'h0000_0001;
    @(negedge clock); start_a = 1'b1;
    watch(1'b0, 0, lat, rdc, acc, dn, pd, td);
    total++;
    if (lat !== 3 || dn !== 1 || pd !== 1'b0 || td !== 1'b0 || id_value_a !== 32'd1 || pass_a !== 1'b0) begin
      bad++; $display("FAIL id_mismatch got lat=%0d done=%0d pass=%b to=%b id=%h held=%b want 3 1 0 0 1 0",
                      lat, dn, pd, td, id_value_a, pass_a);
    end
    id_word_a = 32'd0;
  endtask

  task automatic test_stall_latency();
    int lat, rdc, acc, dn; logic pd, td;
    stall_req_b[0] = 0; stall_req_b[1] = 5;
    @(negedge clock); start_b = 1'b1;
    watch(1'b1, 0, lat, rdc, acc, dn, pd, td);
    total++;
    if (lat !== 12 || acc !== 2 || rdc !== 7 || pd !== 1'b1 || ts_value_b !== EXP_TS) begin
      bad++; $display("FAIL stall_latency got lat=%0d acc=%0d rd=%0d pass=%b ts=%h want 12 2 7 1 %h", lat, acc, rdc, pd, ts_value_b, EXP_TS);
    end
  endtask

  task automatic test_timeout();
    int lat, rdc, acc, dn; logic pd, td;
    stall_req_b[0] = 1000; stall_req_b[1] = 0;
    @(negedge clock); start_b = 1'b1;
    watch(1'b1, 0, lat, rdc, acc, dn, pd, td);
    total++;
    if (lat !== B_TO + 1 || rdc !== B_TO || acc !== 0 || dn !== 1 || td !== 1'b1 || pd !== 1'b0) begin
      bad++; $display("FAIL timeout got lat=%0d rd=%0d acc=%0d done=%0d to=%b pass=%b want %0d %0d 0 1 1 0",
                      lat, rdc, acc, dn, td, pd, B_TO + 1, B_TO);
    end
    total++;
    if (timeout_b !== 1'b1 || pass_b !== 1'b0 || id_value_b !== mdl_id_b || ts_value_b !== mdl_ts_b) begin
      bad++; $display("FAIL timeout_hold got to=%b pass=%b id=%h ts=%h want 1 0 %h %h", timeout_b, pass_b, id_value_b, ts_value_b, mdl_id_b, mdl_ts_b);
    end
    stall_req_b[0] = 0;
    @(negedge clock); start_b = 1'b1;
    watch(1'b1, 0, lat, rdc, acc, dn, pd, td);
    total++;
    if (timeout_b !== 1'b0 || pass_b !== 1'b1 || td !== 1'b0) begin
      bad++; $display("FAIL timeout_clear got to=%b pass=%b want 0 1", timeout_b, pass_b);
    end
  endtask

  task automatic test_busy_restart();
    int lat, rdc, acc, dn; logic pd, td;
    @(negedge clock); start_a = 1'b1;
    watch(1'b0, 2, lat, rdc, acc, dn, pd, td);
    total++;
    if (dn !== 1 || acc !== 2 || rdc !== 2 || lat !== 3) begin
      bad++; $display("FAIL busy_restart got done=%0d acc=%0d rd=%0d lat=%0d want 1 2 2 3", dn, acc, rdc, lat);
    end
  endtask

  task automatic test_random_a();
    int lat, rdc, acc, dn; logic pd, td, exp_pass;
    for (int it = 0; it < 8; it++) begin
      id_word_a = $urandom_range(0, 1) ? 32'd0 : $urandom;
      ts_word_a = $urandom_range(0, 1) ? EXP_TS : $urandom;
      exp_pass  = (id_word_a == 32'd0) && (ts_word_a == EXP_TS);
      @(negedge clock); start_a = 1'b1;
      watch(1'b0, 0, lat, rdc, acc, dn, pd, td);
      total++;
      if (lat !== 3 || pd !== exp_pass || pass_a !== exp_pass || id_value_a !== id_word_a || ts_value_a !== ts_word_a) begin
        bad++; $display("FAIL rand_a it=%0d got lat=%0d pass=%b id=%h ts=%h want 3 %b %h %h",
                        it, lat, pd, id_value_a, ts_value_a, exp_pass, id_word_a, ts_word_a);
      end
    end
    id_word_a = 32'd0; ts_word_a = EXP_TS;
  endtask

  task automatic test_random_b();
    int lat, rdc, acc, dn, s0, s1, e_lat, e_rd, e_acc; logic pd, td, e_to, e_pass;
    for (int it = 0; it < 12; it++) begin
      s0 = $urandom_range(0, 9); s1 = $urandom_range(0, 9);
      id_word_b = $urandom_range(0, 1) ? B_EXP_ID : $urandom;
      ts_word_b = $urandom_range(0, 1) ? EXP_TS : $urandom;
      stall_req_b[0] = s0; stall_req_b[1] = s1;
      if (s0 >= B_TO) begin
        e_to = 1'b1; e_lat = B_TO + 1; e_rd = B_TO; e_acc = 0;
      end else if (s1 >= B_TO) begin
        e_to = 1'b1; e_lat = 2 + s0 + B_LAT + B_TO; e_rd = s0 + 1 + B_TO; e_acc = 1;
        mdl_id_b = id_word_b;
      end else begin
        e_to = 1'b0; e_lat = 3 + s0 + s1 + 2 * B_LAT; e_rd = s0 + s1 + 2; e_acc = 2;
        mdl_id_b = id_word_b; mdl_ts_b = ts_word_b;
      end
      e_pass = !e_to && (mdl_id_b == B_EXP_ID) && (mdl_ts_b == EXP_TS);
      @(negedge clock); start_b = 1'b1;
      watch(1'b1, 0, lat, rdc, acc, dn, pd, td);
      total++;
      if (lat !== e_lat || rdc !== e_rd || acc !== e_acc || td !== e_to || pd !== e_pass ||
          id_value_b !== mdl_id_b || ts_value_b !== mdl_ts_b) begin
        bad++; $display("FAIL rand_b it=%0d s=%0d/%0d got lat=%0d rd=%0d acc=%0d to=%b pass=%b id=%h ts=%h want %0d %0d %0d %b %b %h %h",
                        it, s0, s1, lat, rdc, acc, td, pd, id_value_b, ts_value_b,
                        e_lat, e_rd, e_acc, e_to, e_pass, mdl_id_b, mdl_ts_b);
      end
    end
    stall_req_b[0] = 0; stall_req_b[1] = 0;
    id_word_b = B_EXP_ID; ts_word_b = EXP_TS;
  endtask

  task automatic test_reset_midop();
    int lat, rdc, acc, dn; logic pd, td;
    @(negedge clock); start_b = 1'b1;
    @(posedge clock);
    @(negedge clock); start_b = 1'b0;
    repeat (4) @(negedge clock);
    total++;
    if (busy_b !== 1'b1 || av_read_b !== 1'b0 || id_value_b !== B_EXP_ID) begin
      bad++; $display("FAIL pre_reset got busy=%b rd=%b id=%h want 1 0 %h", busy_b, av_read_b, id_value_b, B_EXP_ID);
    end
    #1 rst_b = 1'b0;
    #1;
    total++;
    if ({av_read_b, av_address_b, busy_b, done_b, pass_b, timeout_b, id_value_b, ts_value_b} !== 70'd0) begin
      bad++; $display("FAIL async_reset got=%b%b%b%b%b%b %h %h want=all_zero", av_read_b, av_address_b,
                      busy_b, done_b, pass_b, timeout_b, id_value_b, ts_value_b);
    end
    repeat (2) @(negedge clock);
    rst_b = 1'b1;
    watch(1'b1, 0, lat, rdc, acc, dn, pd, td);
    total++;
    if (lat !== 3 + 2 * B_LAT || pd !== 1'b1 || pass_b !== 1'b1 || id_value_b !== B_EXP_ID || ts_value_b !== EXP_TS) begin
      bad++; $display("FAIL rerun got lat=%0d pass=%b held=%b id=%h ts=%h want %0d 1 1 %h %h",
                      lat, pd, pass_b, id_value_b, ts_value_b, 3 + 2 * B_LAT, B_EXP_ID, EXP_TS);
    end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_id_mismatch();
    test_stall_latency();
    test_timeout();
    test_busy_restart();
    test_random_a();
    test_random_b();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID control slave.
- On a start request it reads word 0 (system ID) and word 1 (build timestamp), captures both, and compares them against build-time expected values.
- Reports pass/fail and timeout, so boot logic or a debug LED can flag a mismatched FPGA image/software pairing without CPU involvement.

Parameters:
EXPECTED_ID, 32'd0, value required at address 0.
EXPECTED_TIMESTAMP, 32'd1363017989, value required at address 1.
READ_LATENCY, 0, fixed slave read latency in cycles after command acceptance; legal range 0..3 (0 = combinational slave).
TIMEOUT, 255, max consecutive waitrequest cycles on one read before abort; legal range 1..65535.
AUTO_START, 1, 1 = perform one check automatically after reset release.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run a check; ignored while busy
av_address  out  1  slave word address (0 = ID, 1 = timestamp)
av_read  out  1  read strobe
av_waitrequest  in  1  slave stall; tie 0 for the sysid slave
av_readdata  in  32  slave read data
busy  out  1  check in progress
done  out  1  one-cycle pulse at end of every check (pass, fail or timeout)
pass  out  1  last check matched both words; held until next check starts
timeout  out  1  last check aborted on waitrequest; held until next check starts
id_value  out  32  captured address-0 word
ts_value  out  32  captured address-1 word

Behaviour:
- Reset is asynchronous, active-low, and can take effect mid-operation: FSM goes to IDLE. All outputs reset to 0, including av_read, av_address, pass, timeout, done, busy, id_value and ts_value; the latency and timeout counters also clear.
- Clock and reset are named clock and reset_n, matching the codebase's Avalon components.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH.
- IDLE:
  - Trigger is start=1, or the first cycle after reset release when AUTO_START=1 (one-shot flag).
  - On trigger: go to RD_ID, clear pass and timeout, set busy.
  - start while not in IDLE is dropped, not queued.
- RD_ID:
  - av_read=1, av_address=0.
  - Acceptance is an edge with av_read=1 and av_waitrequest=0.
  - READ_LATENCY=0: capture av_readdata into id_value on the accept edge, then go to RD_TS.
  - READ_LATENCY>0: deassert av_read, go to LAT_ID.
- LAT_ID: count READ_LATENCY cycles; capture av_readdata on the edge ending cycle READ_LATENCY after acceptance, then go to RD_TS.
- RD_TS / LAT_TS: identical to RD_ID / LAT_ID, but with av_address=1 and capture into ts_value; exit to FINISH.
- FINISH (one cycle):
  - done=1.
  - pass = (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TIMESTAMP) && !timeout.
  - busy=0 on exit; next state IDLE.
- Timeout:
  - 16-bit counter increments each edge in RD_* with av_waitrequest=1, and clears on acceptance and on state entry.
  - When it reaches TIMEOUT: set timeout=1, drop av_read, skip the remaining reads, go to FINISH; pass=0.
  - Uncaptured value registers keep their previous contents.
- Latency at READ_LATENCY=0 with no stalls: trigger edge -> RD_ID cycle -> RD_TS cycle -> FINISH cycle. done is visible 3 cycles after start is sampled.
- Avalon rules:
  - av_address is stable while av_read=1.
  - av_read is never asserted in IDLE, LAT_* or FINISH.
  - Exactly one transfer is issued per RD_* state.
- pass is combinational from captured registers only at the FINISH transition and is registered thereafter; it never toggles in any other state.

Decomposition:
- Shared package sysid_pkg holds:
  - state enum encoding;
  - SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1 constants;
  - default expected values, so the slave generator and this checker share one source.
- One natural sub-module, sysid_read_engine: performs a single Avalon read (address in, latency and timeout counting, data/valid/timeout out). The top FSM sequences it twice.

Test Plan:
1. Model the sysid slave as readdata = address ? 1363017989 : 0 with waitrequest=0; AUTO_START=1; release reset. Required: av_read high for 2 consecutive cycles (address 0 then 1); done pulses on the 3rd cycle with pass=1; id_value=0; ts_value=1363017989.
2. Change the slave ID word to 32'h0000_0001; pulse start. Required: done pulses with pass=0, timeout=0, id_value=1.
3. Set waitrequest=1 for 5 cycles on the timestamp read; READ_LATENCY=2. Required: address 1 held stable through the stall; capture 2 cycles after acceptance; pass=1; done 3+5+4 cycles after start.
4. TIMEOUT=8 with waitrequest stuck at 1. Required: av_read drops after 8 stalled cycles; timeout=1, pass=0, done pulse; a subsequent start clears timeout.
5. Pulse start again while busy. Required: ignored; exactly one done pulse and two reads.
6. Assert reset_n=0 during LAT_TS. Required: all outputs go to 0 immediately, asynchronously; after release with AUTO_START=1, a full check reruns and passes.
